// File: rtl/part3_mac_pkg.sv
// Shared definitions for the pipelined signed MAC: default widths, the
// per-stage valid/clear control bundle and the overflow-aware adder.
// Optional build macro used by this slice: PART3_MAC_SATURATE_EN.
package part3_mac_pkg;

    localparam int IN_W_DEF  = 10;
    localparam int OUT_W_DEF = 20;

    // Working width of sat_add; callers sign-extend into it. The accumulator
    // width must leave at least one spare bit for the carry.
    localparam int SAT_W = 64;

    // Control bits that travel alongside each sample through the pipeline.
    typedef struct packed {
        logic valid;
        logic clear;
    } ctl_t;

    // Result of one accumulate step.
    typedef struct packed {
        logic                    ovf;
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] sat;
    } sat_res_t;

    // Adds two out_w-bit signed values (already sign-extended to SAT_W).
    // Overflow is flagged when the carry bit (bit out_w) differs from the
    // sign bit (bit out_w-1) of the out_w+1-bit sum. On overflow the
    // clamped value follows the sign of the true sum.
    function automatic sat_res_t sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] prod,
        input int                      out_w
    );
        sat_res_t                r;
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        s     = acc + prod;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        r.sum = s;
        r.ovf = s[out_w] ^ s[out_w-1];
        if (!r.ovf) begin
            r.sat = s;
        end else if (s[out_w]) begin
            r.sat = min_v;
        end else begin
            r.sat = max_v;
        end
        return r;
    endfunction

endpackage

// File: rtl/part3_mult_stage.sv
// Input register stage of the MAC plus an optional product register.
// With PIPE_MULT=0 the product is formed combinationally from the input
// registers; with PIPE_MULT=1 it is registered together with its control.
module part3_mult_stage
    import part3_mac_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int PIPE_MULT = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [IN_W-1:0]   a,
    input  logic signed [IN_W-1:0]   b,
    input  logic                     valid_in,
    input  logic                     clear_acc,
    output logic signed [2*IN_W-1:0] prod,
    output ctl_t                     ctl
);

    logic signed [IN_W-1:0]   a_reg;
    logic signed [IN_W-1:0]   b_reg;
    ctl_t                     ctl_reg;
    logic signed [2*IN_W-1:0] prod_next;

    // Stage 1: capture operands and their control on every edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            ctl_reg <= '0;
        end else begin
            a_reg   <= a;
            b_reg   <= b;
            ctl_reg <= '{valid: valid_in, clear: clear_acc};
        end
    end

    assign prod_next = a_reg * b_reg;

    generate
        if (PIPE_MULT != 0) begin : g_pipe
            logic signed [2*IN_W-1:0] prod_reg;
            ctl_t                     ctl_p_reg;

            // Stage 2: register the product so the multiplier gets a full cycle.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    prod_reg  <= '0;
                    ctl_p_reg <= '0;
                end else begin
                    prod_reg  <= prod_next;
                    ctl_p_reg <= ctl_reg;
                end
            end

            assign prod = prod_reg;
            assign ctl  = ctl_p_reg;
        end else begin : g_comb
            assign prod = prod_next;
            assign ctl  = ctl_reg;
        end
    endgenerate

endmodule

// File: rtl/part3_mac_pipe.sv
// Pipelined signed multiply-accumulate with in-band restart (clear_acc).
// Latency from sampling to f/valid_out is 2 edges, plus 1 with PIPE_MULT=1.
// Build macro PART3_MAC_SATURATE_EN: clamp on overflow and report a sticky
// overflow flag; otherwise the accumulator wraps and overflow reads 0.
module part3_mac_pipe
    import part3_mac_pkg::*;
#(
    parameter int IN_W      = IN_W_DEF,
    parameter int OUT_W     = OUT_W_DEF,
    parameter int PIPE_MULT = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [IN_W-1:0]  a,
    input  logic signed [IN_W-1:0]  b,
    input  logic                    valid_in,
    input  logic                    clear_acc,
    output logic signed [OUT_W-1:0] f,
    output logic                    valid_out,
    output logic                    overflow
);

    generate
        if (OUT_W < 2 * IN_W) begin : g_bad_width
            $error("part3_mac_pipe: OUT_W must be at least 2*IN_W");
        end
        if (OUT_W + 1 > SAT_W) begin : g_bad_sat_width
            $error("part3_mac_pipe: OUT_W too wide for sat_add");
        end
    endgenerate

    logic signed [2*IN_W-1:0] prod;
    ctl_t                     ctl;
    logic signed [OUT_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  f_reg;
    logic signed [OUT_W-1:0]  f_next;
    logic                     valid_out_reg;

    part3_mult_stage #(
        .IN_W      (IN_W),
        .PIPE_MULT (PIPE_MULT)
    ) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .a         (a),
        .b         (b),
        .valid_in  (valid_in),
        .clear_acc (clear_acc),
        .prod      (prod),
        .ctl       (ctl)
    );

    // Sign-extend the product up to the accumulator width, one bit per copy.
    assign prod_ext[2*IN_W-1:0] = prod;
    generate
        for (genvar gi = 2 * IN_W; gi < OUT_W; gi++) begin : g_sext
            assign prod_ext[gi] = prod[2*IN_W-1];
        end
    endgenerate

`ifdef PART3_MAC_SATURATE_EN
    logic                    ovf_reg;
    logic                    ovf_next;
    logic signed [SAT_W-1:0] acc_wide;
    logic signed [SAT_W-1:0] prod_wide;
    sat_res_t                add_res;
    logic                    unused_sat_bits;

    assign acc_wide  = {{(SAT_W-OUT_W){f_reg[OUT_W-1]}}, f_reg};
    assign prod_wide = {{(SAT_W-OUT_W){prod_ext[OUT_W-1]}}, prod_ext};
    assign add_res   = sat_add(acc_wide, prod_wide, OUT_W);
    assign unused_sat_bits = ^{add_res.sum, add_res.sat[SAT_W-1:OUT_W]};

    // Next accumulator: restart on clear, clamped add on a plain valid sample.
    always_comb begin
        f_next   = f_reg;
        ovf_next = ovf_reg;
        if (ctl.clear) begin
            f_next   = ctl.valid ? prod_ext : '0;
            ovf_next = 1'b0;
        end else if (ctl.valid) begin
            f_next   = add_res.sat[OUT_W-1:0];
            ovf_next = ovf_reg | add_res.ovf;
        end
    end

    // Sticky overflow register; cleared by reset or either form of clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign overflow = ovf_reg;
`else
    // Next accumulator: restart on clear, wrapping add on a plain valid sample.
    always_comb begin
        f_next = f_reg;
        if (ctl.clear) begin
            f_next = ctl.valid ? prod_ext : '0;
        end else if (ctl.valid) begin
            f_next = f_reg + prod_ext;
        end
    end

    assign overflow = 1'b0;
`endif

    // Accumulate stage: f and its valid pulse update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_reg         <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            f_reg         <= f_next;
            valid_out_reg <= ctl.valid;
        end
    end

    assign f         = f_reg;
    assign valid_out = valid_out_reg;

endmodule

// File: tb/tb_part3_mac_pipe.sv
// Directed bench: two MAC instances (PIPE_MULT=0 and 1) share one stimulus
// stream; each is checked at its own latency. One line per transaction.
module tb_part3_mac_pipe;

    localparam int IN_W  = 10;
    localparam int OUT_W = 20;
    localparam int N_RND = 16;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic signed [IN_W-1:0]  a = '0;
    logic signed [IN_W-1:0]  b = '0;
    logic                    valid_in = 1'b0;
    logic                    clear_acc = 1'b0;
    logic signed [OUT_W-1:0] f0, f1;
    logic                    vo0, vo1, ov0, ov1;

    int checks = 0;
    int errors = 0;

    int ra [N_RND];
    int rb [N_RND];
    int rc [N_RND];
    int rexp [N_RND];

    always #5 clk = ~clk;

    part3_mac_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .PIPE_MULT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .valid_in(valid_in),
        .clear_acc(clear_acc), .f(f0), .valid_out(vo0), .overflow(ov0)
    );

    part3_mac_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .PIPE_MULT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .a(a), .b(b), .valid_in(valid_in),
        .clear_acc(clear_acc), .f(f1), .valid_out(vo1), .overflow(ov1)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check f/valid_out/overflow of one instance.
    task automatic check_out(input string tag, input int which, input int ef,
                             input int ev, input int eo);
        if (which == 0) begin
            check({tag, ".f0"}, f0, ef);
            check({tag, ".vo0"}, {31'd0, vo0}, ev);
            check({tag, ".ov0"}, {31'd0, ov0}, eo);
        end else begin
            check({tag, ".f1"}, f1, ef);
            check({tag, ".vo1"}, {31'd0, vo1}, ev);
            check({tag, ".ov1"}, {31'd0, ov1}, eo);
        end
    endtask

    // Drive one sample at the falling edge, then step past the next rising edge.
    task automatic cyc(input int v, input int c, input int av, input int bv);
        @(negedge clk);
        valid_in  = v[0];
        clear_acc = c[0];
        a         = IN_W'(av);
        b         = IN_W'(bv);
        @(posedge clk);
        #1;
        $display("t=%0t v=%0d c=%0d a=%0d b=%0d | f0=%0d vo0=%0d ov0=%0d | f1=%0d vo1=%0d ov1=%0d",
                 $time, v, c, av, bv, f0, vo0, ov0, f1, vo1, ov1);
    endtask

    int sat_ovf;
    int e9, e10;

    initial begin
`ifdef PART3_MAC_SATURATE_EN
        sat_ovf = 1; e9 = 524287; e10 = 524287;
`else
        sat_ovf = 0; e9 = -524288; e10 = -262144;
`endif
        // Reset held with active-looking inputs.
        valid_in = 1'b1; a = 10'sd5; b = 10'sd5;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            $display("t=%0t reset cycle %0d f0=%0d vo0=%0d f1=%0d vo1=%0d", $time, i, f0, vo0, f1, vo1);
            check_out("rst", 0, 0, 0, 0);
            check_out("rst", 1, 0, 0, 0);
        end
        @(negedge clk);
        valid_in = 1'b0;
        reset_n  = 1'b1;

        // Basic accumulation, bubbles, restart.
        cyc(1, 1, 3, 4);
        cyc(1, 0, -5, 6);   check_out("acc12", 0, 12, 1, 0);
        cyc(0, 0, 0, 0);    check_out("acc-18", 0, -18, 1, 0); check_out("p_acc12", 1, 12, 1, 0);
        cyc(0, 0, 0, 0);    check_out("bub1", 0, -18, 0, 0);   check_out("p_acc-18", 1, -18, 1, 0);
        cyc(0, 0, 0, 0);    check_out("bub2", 0, -18, 0, 0);   check_out("p_bub1", 1, -18, 0, 0);
        cyc(1, 1, 2, 2);    check_out("bub3", 0, -18, 0, 0);   check_out("p_bub2", 1, -18, 0, 0);
        cyc(1, 1, -512, -512); check_out("restart4", 0, 4, 1, 0); check_out("p_bub3", 1, -18, 0, 0);
        cyc(1, 0, -512, -512); check_out("big1", 0, 262144, 1, 0); check_out("p_restart4", 1, 4, 1, 0);
        cyc(1, 0, -512, -512); check_out("big2", 0, e9, 1, sat_ovf); check_out("p_big1", 1, 262144, 1, 0);
        cyc(0, 0, 0, 0);    check_out("big3", 0, e10, 1, sat_ovf); check_out("p_big2", 1, e9, 1, sat_ovf);
        cyc(0, 0, 0, 0);    check_out("big_hold", 0, e10, 0, sat_ovf); check_out("p_big3", 1, e10, 1, sat_ovf);

        // Clear without a valid sample zeroes f and overflow, no pulse.
        cyc(0, 1, 0, 0);    check_out("pre_clr", 0, e10, 0, sat_ovf);
        cyc(0, 0, 0, 0);    check_out("clr_nv", 0, 0, 0, 0);
        cyc(0, 0, 0, 0);    check_out("p_clr_nv", 1, 0, 0, 0);

        // Asynchronous reset with two samples in flight.
        cyc(1, 1, 7, 7);
        cyc(1, 0, 1, 1);    check_out("pre_arst", 0, 49, 1, 0);
        #2;
        valid_in  = 1'b0;
        clear_acc = 1'b0;
        reset_n   = 1'b0;
        #1;
        $display("t=%0t async reset f0=%0d vo0=%0d f1=%0d vo1=%0d", $time, f0, vo0, f1, vo1);
        check_out("arst", 0, 0, 0, 0);
        check_out("arst", 1, 0, 0, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            check_out("post_arst", 0, 0, 0, 0);
            check_out("post_arst", 1, 0, 0, 0);
        end

        // Back-to-back random stream against a running-sum model.
        for (int i = 0; i < N_RND; i++) begin
            ra[i] = int'($urandom_range(40)) - 20;
            rb[i] = int'($urandom_range(40)) - 20;
            rc[i] = (i == 0 || i == 9) ? 1 : 0;
            rexp[i] = (rc[i] != 0) ? ra[i] * rb[i] : rexp[i-1] + ra[i] * rb[i];
        end
        for (int i = 0; i < N_RND + 2; i++) begin
            if (i < N_RND) cyc(1, rc[i], ra[i], rb[i]);
            else           cyc(0, 0, 0, 0);
            if (i >= 1 && i <= N_RND) check_out("rnd", 0, rexp[i-1], 1, 0);
            if (i >= 2)               check_out("p_rnd", 1, rexp[i-2], 1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
